pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//  Generic, parametrised pipeline-stage register carrying WIDTH bits of packed stage fields
//  (e.g. the D->E bundle) with valid/ready handshake, 2-entry skid buffer, synchronous flush.
//  Replaces per-stage hand-written flop banks; registered in_ready breaks the stall path.
//  Every output bit has a defined reset/flush value.
//  Sits between any two stages (F/D, D/E, E/M, M/W) of the RV32I pipeline.
// PARAMETERS
//  WIDTH    178          payload width in bits (D/E bundle; field offsets in pipe_pkg)
//  CLR_MASK {WIDTH{1'b1}} bit=1 -> payload bit forced to CLR_VAL bit on flush; bit=0 -> holds
//  CLR_VAL  {WIDTH{1'b0}} value loaded on reset (all bits) and on flush (CLR_MASK bits)
//  CNT_W    8            width of saturating flushed-beat counter
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-low reset
//  flush      in   1      synchronous flush, active high
//  in_valid   in   1      upstream beat valid
//  in_data    in   WIDTH  upstream payload
//  in_ready   out  1      stage can accept (= !skid_valid && !flush && reset)
//  out_valid  out  1      payload valid to downstream
//  out_data   out  WIDTH  payload to downstream (main register)
//  out_ready  in   1      downstream accepts (0 = stall)
//  occupancy  out  2      beats held: 0,1,2
//  flush_drop out  CNT_W  count of valid beats discarded by flush, saturating
// BEHAVIOUR
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Reset (reset==0 at posedge): out_valid=0, skid_valid=0, out_data=CLR_VAL, skid_data=CLR_VAL,
//    occupancy=0, flush_drop=0. Reset beats flush beats all else. in_ready=0 while reset low.
//  - Flush (reset==1, flush==1): out_valid=0, skid_valid=0; out_data/skid_data bits under CLR_MASK
//    <= CLR_VAL, others hold; in_ready=0 that cycle so no input is taken; out_fire same cycle
//    still counts as delivered. flush_drop += (out_valid & !out_ready) + skid_valid, saturating at
//    2^CNT_W-1.
//  - Normal (reset==1, flush==0), per posedge:
//    * main empty or out_fire: main <= skid if skid_valid, else in_data if in_fire;
//      out_valid <= skid_valid | in_fire; if skid was used and in_fire, in_data -> skid,
//      else skid_valid <= 0.
//    * main full and !out_ready: in_fire loads skid (skid_valid<=1); else all hold.
//  - Latency: 1 cycle in_fire -> out_valid when empty. Throughput 1 beat/cycle sustained.
//  - in_ready registered-derived: deasserts the cycle after skid fills; at most one extra beat
//    accepted after out_ready drops. Never more than 2 beats stored; no beat lost or duplicated.
//  - Order strictly FIFO: main always older than skid.
//  - occupancy = out_valid + skid_valid.
//  - out_data stable while out_valid & !out_ready (AXI-style hold rule).
//  - in_data ignored when !in_fire; payload X-free after reset.
// STRUCTURE
//  - pipe_pkg: DE_W=178, field offsets/widths (RD1,RD2,PC,Rs1,Rs2,Rd,ImmExt,PCPlus4,Func3),
//    pack/unpack functions, default CLR_VAL/CLR_MASK constants per stage.
//  - One sub-module: stage_slot (WIDTH data + valid flop, load/clear inputs, CLR_MASK/CLR_VAL);
//    instantiated twice (main, skid). Top holds steering mux, in_ready, counters.
// TESTING
//  1. reset=0 2 cycles, in_valid=1 -> out_valid=0, out_data=CLR_VAL, in_ready=0, flush_drop=0.
//  2. Stream 0x1..0x8, out_ready=1 -> out beats 0x1..0x8 one per cycle, 1-cycle latency, occ<=1.
//  3. Stream A,B,C; drop out_ready after A out -> B held in main, C in skid, in_ready=0,
//     occupancy=2; raise out_ready -> B then C, no loss, no duplication.
//  4. occupancy=2, flush=1 with out_ready=0 -> out_valid=0 next cycle, flush_drop=2,
//     CLR_MASK bits=CLR_VAL, unmasked bits hold; same-cycle in_valid beat not taken.
//  5. CNT_W=2, repeat flush of 2 beats 3 times -> flush_drop saturates at 3.
//  6. Random valid/ready/flush 10k cycles vs scoreboard -> order kept, out_data stable under
//     stall, occupancy never >2; reset mid-stream -> all state cleared next cycle.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// pipe_stage_skid_pkg: D/E bundle layout and default stage clear constants
package pipe_stage_skid_pkg;
  localparam int DE_W = 178;
  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm_ext;
    logic [31:0] pc_plus4;
    logic [2:0]  func3;
  } de_t;
  localparam logic [DE_W-1:0] DE_CLR_VAL  = '0;
  localparam logic [DE_W-1:0] DE_CLR_MASK = '1;
  function automatic logic [DE_W-1:0] de_pack(de_t f);
    return f;
  endfunction
  function automatic de_t de_unpack(logic [DE_W-1:0] v);
    return v;
  endfunction
endpackage

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: valid/ready/data handshake between pipeline stages
interface pipe_stage_skid_if import pipe_stage_skid_pkg::*; #(
  parameter int WIDTH = DE_W
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  modport master(output valid, data, input ready);
  modport slave(input valid, data, output ready);
endinterface

// File: rtl/pipe_stage_skid_slot.sv
// pipe_stage_skid_slot: one payload register plus valid flag with reset and masked flush clear
module pipe_stage_skid_slot #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] CLR_MASK = '1,
  parameter logic [WIDTH-1:0] CLR_VAL  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             ld,
  input  logic             vld_n,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;
  always_comb begin
    valid_d = ~flush & vld_n;
    data_d  = flush ? (data_q & ~CLR_MASK) | (CLR_VAL & CLR_MASK) : ld ? d : data_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= CLR_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid = valid_q;
  assign data  = data_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline register with 2-entry skid buffer, masked flush and flushed-beat counter
module pipe_stage_skid import pipe_stage_skid_pkg::*; #(
  parameter int               WIDTH    = DE_W,
  parameter logic [WIDTH-1:0] CLR_MASK = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] CLR_VAL  = '0,
  parameter int               CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  pipe_stage_skid_if.slave   up,
  pipe_stage_skid_if.master  dn,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   flush_drop
);
  logic             skid_valid, main_free, in_fire;
  logic             main_ld, main_vld, skid_ld, skid_vld;
  logic [WIDTH-1:0] skid_data, main_d;
  logic [CNT_W:0]   drop_sum;
  logic [CNT_W-1:0] drop_d, drop_q;
  assign up.ready = reset & ~flush & ~skid_valid;
  always_comb begin
    in_fire   = up.valid & up.ready;
    main_free = ~dn.valid | dn.ready;
    main_ld   = main_free & (skid_valid | in_fire);
    main_vld  = main_free ? skid_valid | in_fire : 1'b1;
    main_d    = skid_valid ? skid_data : up.data;
    skid_ld   = in_fire & (~main_free | skid_valid);
    skid_vld  = main_free ? skid_valid & in_fire : skid_valid | in_fire;
    // beats lost to flush: a stalled main beat plus any skid beat
    drop_sum  = {1'b0, drop_q} + (CNT_W+1)'(dn.valid & ~dn.ready) + (CNT_W+1)'(skid_valid);
    drop_d    = flush ? (drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0]) : drop_q;
    occupancy = {1'b0, dn.valid} + {1'b0, skid_valid};
  end
  always_ff @(posedge clk) begin
    if (!reset) drop_q <= '0;
    else drop_q <= drop_d;
  end
  assign flush_drop = drop_q;
  pipe_stage_skid_slot #(.WIDTH(WIDTH), .CLR_MASK(CLR_MASK), .CLR_VAL(CLR_VAL)) u_main (
    .clk(clk), .reset(reset), .flush(flush), .ld(main_ld), .vld_n(main_vld),
    .d(main_d), .valid(dn.valid), .data(dn.data)
  );
  pipe_stage_skid_slot #(.WIDTH(WIDTH), .CLR_MASK(CLR_MASK), .CLR_VAL(CLR_VAL)) u_skid (
    .clk(clk), .reset(reset), .flush(flush), .ld(skid_ld), .vld_n(skid_vld),
    .d(up.data), .valid(skid_valid), .data(skid_data)
  );
endmodule
